// File: rtl/tiny_rv_bus_pkg.sv
// tiny_rv_bus_pkg: shared bus types and widths for the core memory path
package tiny_rv_bus_pkg;
    localparam int XLEN = 32;
    localparam int BE_W = 4;
    typedef enum logic {SRC_I = 1'b0, SRC_D = 1'b1} bus_src_e;
endpackage

// File: rtl/arb_id_fifo.sv
// arb_id_fifo: in-order FIFO of request source IDs for outstanding memory requests
module arb_id_fifo
    import tiny_rv_bus_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  bus_src_e din,
    output bus_src_e dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    bus_src_e mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I and D sides, D priority with I starvation guard.
// Define ARB_RR_EN for round-robin arbitration instead.
module mem_port_arbiter
    import tiny_rv_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [XLEN-1:0] i_rd_data,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [BE_W-1:0] d_we,
    input  logic [XLEN-1:0] d_wr_data,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rd_data,
    output logic            m_req,
    output logic [XLEN-1:0] m_addr,
    output logic [BE_W-1:0] m_we,
    output logic [XLEN-1:0] m_wr_data,
    input  logic            m_gnt,
    input  logic            m_rvalid,
    input  logic [XLEN-1:0] m_rd_data,
    output logic            err
);
    logic sel_i, grant, pop, full, empty;
    bus_src_e head;
`ifdef ARB_RR_EN
    bus_src_e last;
    assign sel_i = i_req & (!d_req | last == SRC_D);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last <= SRC_I;
        else if (grant) last <= sel_i ? SRC_I : SRC_D;
    end
`else
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;
    assign sel_i = i_req & (!d_req | starve_cnt == LIMIT);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) starve_cnt <= '0;
        else if (!i_req || i_gnt) starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
    end
`endif
    // outputs are gated by rst so nothing leaks out while reset is held
    assign m_req     = rst & (i_req | d_req) & !full;
    assign grant     = m_req & m_gnt;
    assign i_gnt     = grant & sel_i;
    assign d_gnt     = grant & !sel_i;
    assign m_addr    = sel_i ? i_addr : d_addr;
    assign m_we      = sel_i ? '0 : d_we;
    assign m_wr_data = sel_i ? '0 : d_wr_data;
    assign pop       = rst & m_rvalid & !empty;
    assign i_rvalid  = pop & (head == SRC_I);
    assign d_rvalid  = pop & (head == SRC_D);
    assign i_rd_data = m_rd_data;
    assign d_rd_data = m_rd_data;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (m_rvalid && empty) err <= 1'b1;
    end
    arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (pop),
        .din   (sel_i ? SRC_I : SRC_D),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (default build or ARB_RR_EN)
module tb_mem_port_arbiter;
    import tiny_rv_bus_pkg::*;
    logic clk = 1'b0, rst = 1'b0;
    logic i_req = 0, d_req = 0, m_gnt = 0, m_rvalid = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wr_data = 0, m_rd_data = 0;
    logic [3:0] d_we = 0;
    logic i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, err;
    logic [31:0] i_rd_data, d_rd_data, m_addr, m_wr_data;
    logic [3:0] m_we;
    int checks = 0, errors = 0;
    bus_src_e sb [$];
    logic exp_ig [6];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rd_data(i_rd_data),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wr_data(d_wr_data),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rd_data(d_rd_data),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wr_data(m_wr_data),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rd_data(m_rd_data), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // drive one cycle, check at negedge, settle at posedge+1
    task automatic step(input logic ir, input logic dr, input logic mg, input logic mrv,
                        input logic [31:0] rd, input logic eig, input logic edg, input logic emr);
        bus_src_e s;
        i_req = ir; d_req = dr; m_gnt = mg; m_rvalid = mrv; m_rd_data = rd;
        @(negedge clk);
        chk("i_gnt", i_gnt, eig);
        chk("d_gnt", d_gnt, edg);
        chk("m_req", m_req, emr);
        if (eig) begin
            chk("m_addr_i", m_addr, i_addr);
            chk("m_we_i", m_we, 0);
        end
        if (edg) begin
            chk("m_addr_d", m_addr, d_addr);
            chk("m_we_d", m_we, d_we);
            chk("m_wdata_d", m_wr_data, d_wr_data);
        end
        if (mrv) begin
            if (sb.size() > 0) begin
                s = sb.pop_front();
                chk("i_rvalid", i_rvalid, s == SRC_I);
                chk("d_rvalid", d_rvalid, s == SRC_D);
                chk("rd_data", (s == SRC_I) ? i_rd_data : d_rd_data, rd);
            end else begin
                chk("stray_i_rvalid", i_rvalid, 0);
                chk("stray_d_rvalid", d_rvalid, 0);
            end
        end else begin
            chk("idle_rvalid", {i_rvalid, d_rvalid}, 0);
        end
        if (eig) sb.push_back(SRC_I);
        if (edg) sb.push_back(SRC_D);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {i_gnt, d_gnt, m_req, i_rvalid, d_rvalid, err}, 0);
    endtask

    initial begin
        #1 chk_quiet("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        d_addr = 32'h10;
        step(0, 1, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 0, 0, 0, 1, 1);
        i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1;
        #2 rst = 1'b0;
        #1 chk_quiet("mid_burst_reset");
        @(posedge clk);
        #1 chk_quiet("held_reset");
        i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
        rst = 1'b1;
        sb.delete();
        step(0, 0, 0, 1, 32'hDEAD, 0, 0, 0);
        chk("err_sticky", err, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_held", err, 1);
        rst = 1'b0;
        #1 chk("err_cleared", err, 0);
        rst = 1'b1;

        i_addr = 32'h100; d_addr = 32'h200; d_we = 4'hF; d_wr_data = 32'h5555;
`ifdef ARB_RR_EN
        exp_ig = '{0, 1, 0, 1, 0, 1};
`else
        exp_ig = '{0, 0, 0, 0, 1, 0};
`endif
        for (int k = 0; k < 6; k++)
            step(1, 1, 1, k > 0, 32'hC000 + k, exp_ig[k], !exp_ig[k], 1);
        step(0, 0, 1, 1, 32'hC006, 0, 0, 0);

        i_addr = 32'h100; d_addr = 32'h200; d_we = 4'h0;
        step(1, 0, 1, 0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 32'hAAAA, 0, 0, 0);
        step(0, 0, 0, 1, 32'hBBBB, 0, 0, 0);

        i_addr = 32'h300;
        step(1, 0, 1, 0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 32'h1111, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 32'h2222, 0, 0, 0);
        step(0, 0, 0, 1, 32'h3333, 0, 0, 0);

        d_we = 4'b0011; d_addr = 32'h40; d_wr_data = 32'h1234;
        step(0, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 32'h0, 0, 0, 0);
        chk("sb_drained", sb.size(), 0);
        chk("err_clean", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
